md_sequencer: RTL and testbench

//  Sequencer for the E-stage multiply/divide resource. Owns HI/LO and the

---
 rtl/md_defs.sv | 22 ++
 rtl/md_arith.sv | 58 +++++
 rtl/md_sequencer.sv | 107 ++++++++++
 tb/tb_md_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/md_defs.sv
// Shared definitions for the E-stage multiply/divide sequencer.
// Holds the op encodings, the FSM state codes and a small op-decode helper.
package md_defs;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Codes 0..3 are the multi-cycle mult/div family.
  function automatic logic is_muldiv(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply and divide datapath for the MD sequencer.
// Zero latency; divide-by-zero is flagged and the signed-overflow case wraps.
module md_arith
  import md_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        signed_div;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    sprod = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    uprod = {32'd0, src_a} * {32'd0, src_b};

    // Signed divide runs on magnitudes; 0x80000000 / -1 then wraps to 0x80000000.
    signed_div = (op == MD_DIV);
    num = (signed_div && src_a[31]) ? -src_a : src_a;
    den = (signed_div && src_b[31]) ? -src_b : src_b;
    if (den == 32'd0) begin
      den = 32'd1;
    end
    uq = num / den;
    ur = num % den;

    div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (src_b == 32'd0);

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = sprod;
      MD_MULTU: {res_hi, res_lo} = uprod;
      MD_DIV: begin
        res_lo = (src_a[31] ^ src_b[31]) ? -uq : uq;
        res_hi = src_a[31] ? -ur : ur;
      end
      MD_DIVU: begin
        res_lo = uq;
        res_hi = ur;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: owns HI/LO, the latency counter and the
// busy/stall handshake. Result is computed at start and committed after N cycles.
module md_sequencer
  import md_defs::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  md_state_e   state_q;
  md_state_e   state_d;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;
  logic        launch;

  md_arith u_arith (
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        launch = start && is_muldiv(op);
        if (launch) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == 4'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    stall_d = md_use_d && (busy || (start && is_muldiv(op)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (state_q == ST_IDLE) begin
      if (launch) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        // A zero divisor still occupies the unit but leaves HI/LO alone.
        pend_wr <= !div_zero;
        cnt     <= op[1] ? DIV_N : MUL_N;
      end else if (start && (op == MD_MTHI)) begin
        hi <= src_a;
      end else if (start && (op == MD_MTLO)) begin
        lo <= src_a;
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        pend_wr <= 1'b0;
        if (pend_wr) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed mult/div/mthi/mtlo vectors with
// hand-computed HI/LO and busy lengths, checked by a monitor on busy falling.
module tb_md_sequencer;
  import md_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        md_use_d = 1'b0;
  logic        busy;
  logic        stall_d;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   run_len = 0;
  logic prev_busy = 1'b0;

  md_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall_d  (stall_d),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] eh, input logic [31:0] el, input int cyc);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Drives one start pulse; called and returns just after a rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    if (md_use_d && is_muldiv(o)) check("stall_start_cycle", {31'd0, stall_d}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input logic chk_stall);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else if (chk_stall) check("stall_busy_cycle", {31'd0, stall_d}, 32'd1);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: busy still %b after 40 cycles, required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every busy 1->0 transition is a commit point checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      run_len = 0;
    end else begin
      if (busy) begin
        run_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: busy ended with empty scoreboard hi=%h lo=%h", hi, lo);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_hi", hi, e.hi);
          check("sb_lo", lo, e.lo);
          check("sb_busy_len", 32'(run_len), 32'(e.cyc));
        end
        run_len = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    step(3);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_stall", {31'd0, stall_d}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(1);

    // Basic mult/div results
    push(32'hFFFFFFFF, 32'hFFFFFFEB, 5);
    issue(MD_MULT, 32'hFFFFFFFD, 32'd7);
    wait_idle(1'b0);
    push(32'h00000002, 32'h0000000E, 10);
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_idle(1'b0);
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(1'b0);
    push(32'hFFFFFFFE, 32'h00000001, 5);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(1'b0);
    push(32'h00000000, 32'h80000000, 10);
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(1'b0);

    // mthi/mtlo then divide by zero leaves HI/LO untouched
    issue(MD_MTHI, 32'h00000011, 32'd0);
    issue(MD_MTLO, 32'h00000022, 32'd0);
    @(negedge clk);
    check("mthi_11", hi, 32'h00000011);
    check("mtlo_22", lo, 32'h00000022);
    @(posedge clk); #1;
    push(32'h00000011, 32'h00000022, 10);
    issue(MD_DIV, 32'd5, 32'd0);
    wait_idle(1'b0);

    // Undefined op is a no-op
    issue(3'd7, 32'h12345678, 32'd1);
    @(negedge clk);
    check("undef_busy", {31'd0, busy}, 32'd0);
    check("undef_hi", hi, 32'h00000011);
    @(posedge clk); #1;

    // mthi latency and stall handshake
    issue(MD_MTHI, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    check("mthi_hi", hi, 32'hDEADBEEF);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    md_use_d = 1'b1;
    @(negedge clk);
    check("stall_idle", {31'd0, stall_d}, 32'd0);
    @(posedge clk); #1;
    push(32'h00000000, 32'h00000006, 5);
    issue(MD_MULT, 32'd2, 32'd3);
    wait_idle(1'b1);
    @(negedge clk);
    check("stall_after", {31'd0, stall_d}, 32'd0);
    @(posedge clk); #1;
    md_use_d = 1'b0;
    @(negedge clk);
    check("stall_nouse", {31'd0, stall_d}, 32'd0);
    @(posedge clk); #1;

    // start during RUN is ignored
    push(32'h00000002, 32'h0000000E, 10);
    issue(MD_DIVU, 32'd100, 32'd7);
    step(1);
    issue(MD_MULT, 32'd3, 32'd3);
    wait_idle(1'b0);

    // Reset mid-mult aborts without a commit
    push(32'h00000000, 32'h000F4240, 5);
    issue(MD_MULT, 32'd1000, 32'd1000);
    step(2);
    reset = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(12);
    @(negedge clk);
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);
    check("abort_late_busy", {31'd0, busy}, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
